// File: rtl/pe_mem_pkg.sv
// Shared widths and host read-channel request/response types for the PE memory side.
package pe_mem_pkg;

  localparam int unsigned DEF_ADDR_W   = 64;
  localparam int unsigned DEF_DATA_W   = 64;
  localparam int unsigned DEF_TAG_W    = 2;
  localparam int unsigned DEF_NUM_TAGS = 1 << DEF_TAG_W;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_TAG_W-1:0]  tag;
    logic                  val;
  } rd_req_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_TAG_W-1:0]  tag;
    logic                  val;
  } rd_rsp_t;

endpackage

// File: rtl/pe_read_reorder_if.sv
// PE-facing FIFO/response signals plus the tagged host read channel.
interface pe_read_reorder_if
  import pe_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned TAG_W  = DEF_TAG_W
) ();

  logic [ADDR_W-1:0] req_addr;
  logic              req_val;
  logic              req_pop;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_val;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [TAG_W-1:0]  mem_rd_tag;
  logic              mem_rd_val;
  logic              mem_rd_rdy;
  logic [DATA_W-1:0] mem_rsp_data;
  logic [TAG_W-1:0]  mem_rsp_tag;
  logic              mem_rsp_val;
  logic [TAG_W:0]    outstanding;
  logic              err;

  modport slave (
    input  req_addr, req_val, mem_rd_rdy, mem_rsp_data, mem_rsp_tag, mem_rsp_val,
    output req_pop, rsp_data, rsp_val, mem_rd_addr, mem_rd_tag, mem_rd_val, outstanding, err
  );

  modport master (
    output req_addr, req_val, mem_rd_rdy, mem_rsp_data, mem_rsp_tag, mem_rsp_val,
    input  req_pop, rsp_data, rsp_val, mem_rd_addr, mem_rd_tag, mem_rd_val, outstanding, err
  );

endinterface

// File: rtl/pe_rsp_buf.sv
// Per-tag completion buffer: one set-valid write port, one clear-valid read port.
module pe_rsp_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_hit,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic              rd_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int unsigned NumTags = 1 << TAG_W;

  logic [NumTags-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]  data_q [NumTags];
  logic [DATA_W-1:0]  data_d [NumTags];

  assign wr_hit   = valid_q[wr_tag];
  assign rd_valid = valid_q[rd_tag];
  assign rd_data  = data_q[rd_tag];

  // Write only lands on an invalid entry and clear only hits a valid one, so they never collide.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (rd_clr) valid_d[rd_tag] = 1'b0;
    if (wr_en) begin
      valid_d[wr_tag] = 1'b1;
      data_d[wr_tag]  = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pe_read_reorder.sv
// Issues tagged reads from the PE address FIFO and returns completions to the PE in request order.
module pe_read_reorder
  import pe_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned TAG_W  = DEF_TAG_W
) (
  input logic               clk,
  input logic               rst,
  pe_read_reorder_if.slave  bus
);

  localparam int unsigned NUM_TAGS = 1 << TAG_W;
  localparam logic [TAG_W:0] CntFull = (TAG_W+1)'(NUM_TAGS);

  logic [TAG_W-1:0]  iptr_q, iptr_d, rptr_q, rptr_d;
  logic [TAG_W:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [TAG_W-1:0]  rd_tag_q, rd_tag_d;
  logic              rd_val_q, rd_val_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_val_q, rsp_val_d;
  logic              err_q, err_d;

  logic              issue, retire, in_window, rsp_ok, buf_hit, buf_valid;
  logic [TAG_W-1:0]  rsp_off;
  logic [DATA_W-1:0] buf_data;

  assign issue     = bus.req_val & bus.mem_rd_rdy & (cnt_q != CntFull);
  // Tag is outstanding when its distance past rptr (mod NUM_TAGS) is below cnt.
  assign rsp_off   = bus.mem_rsp_tag - rptr_q;
  assign in_window = {1'b0, rsp_off} < cnt_q;
  assign rsp_ok    = bus.mem_rsp_val & in_window & ~buf_hit;
  assign retire    = (cnt_q != '0) & buf_valid;

  pe_rsp_buf #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (rsp_ok),
    .wr_tag   (bus.mem_rsp_tag),
    .wr_data  (bus.mem_rsp_data),
    .wr_hit   (buf_hit),
    .rd_tag   (rptr_q),
    .rd_clr   (retire),
    .rd_data  (buf_data),
    .rd_valid (buf_valid)
  );

  always_comb begin
    iptr_d     = iptr_q;
    rptr_d     = rptr_q;
    rd_addr_d  = rd_addr_q;
    rd_tag_d   = rd_tag_q;
    rd_val_d   = issue;
    rsp_data_d = rsp_data_q;
    rsp_val_d  = retire;
    err_d      = err_q | (bus.mem_rsp_val & ~rsp_ok);
    if (issue) begin
      rd_addr_d = bus.req_addr;
      rd_tag_d  = iptr_q;
      iptr_d    = iptr_q + 1'b1;
    end
    if (retire) begin
      rsp_data_d = buf_data;
      rptr_d     = rptr_q + 1'b1;
    end
    unique case ({issue, retire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      rd_tag_q   <= '0;
      rd_val_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_val_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      iptr_q     <= iptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_tag_q   <= rd_tag_d;
      rd_val_q   <= rd_val_d;
      rsp_data_q <= rsp_data_d;
      rsp_val_q  <= rsp_val_d;
      err_q      <= err_d;
    end
  end

  assign bus.req_pop     = issue;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.mem_rd_tag  = rd_tag_q;
  assign bus.mem_rd_val  = rd_val_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_val     = rsp_val_q;
  assign bus.outstanding = cnt_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_pe_read_reorder.sv
// Scenario-driven bench: expected PE responses are queued at issue time and matched on rsp_val.
module tb_pe_read_reorder;
  import pe_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_read_reorder_if bus ();

  pe_read_reorder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int pops;
  logic [DEF_ADDR_W-1:0] pend_q[$];
  logic [DEF_DATA_W-1:0] exp_q[$];
  logic [DEF_DATA_W-1:0] got_q[$];
  logic [DEF_ADDR_W-1:0] addrs_q[$];
  logic [DEF_TAG_W-1:0]  tags_q[$];

  // One clock: present the PE FIFO head, record what the DUT did, return at posedge+1.
  task automatic step();
    bus.req_val  = (pend_q.size() != 0);
    bus.req_addr = (pend_q.size() != 0) ? pend_q[0] : '0;
    @(negedge clk);
    if (bus.req_pop) begin
      void'(pend_q.pop_front());
      pops++;
    end
    if (bus.rsp_val) got_q.push_back(bus.rsp_data);
    if (bus.mem_rd_val) begin
      tags_q.push_back(bus.mem_rd_tag);
      addrs_q.push_back(bus.mem_rd_addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_rsp(input logic v, input logic [DEF_TAG_W-1:0] t,
                         input logic [DEF_DATA_W-1:0] d);
    bus.mem_rsp_val  = v;
    bus.mem_rsp_tag  = t;
    bus.mem_rsp_data = d;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.req_val    = 1'b0;
    bus.req_addr   = '0;
    bus.mem_rd_rdy = 1'b1;
    set_rsp(1'b0, '0, '0);
    pend_q.delete(); exp_q.delete(); got_q.delete(); addrs_q.delete(); tags_q.delete();
    pops = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 8;
    if (bus.req_pop !== 1'b0) begin errors++; $display("FAIL reset_req_pop got %0h exp 0", bus.req_pop); end
    if (bus.rsp_val !== 1'b0) begin errors++; $display("FAIL reset_rsp_val got %0h exp 0", bus.rsp_val); end
    if (bus.rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %0h exp 0", bus.rsp_data); end
    if (bus.mem_rd_val !== 1'b0) begin errors++; $display("FAIL reset_rd_val got %0h exp 0", bus.mem_rd_val); end
    if (bus.mem_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got %0h exp 0", bus.mem_rd_addr); end
    if (bus.mem_rd_tag !== '0) begin errors++; $display("FAIL reset_rd_tag got %0h exp 0", bus.mem_rd_tag); end
    if (bus.outstanding !== '0) begin errors++; $display("FAIL reset_outstanding got %0h exp 0", bus.outstanding); end
    if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %0h exp 0", bus.err); end
  endtask

  task automatic test_single_read();
    logic [DEF_DATA_W-1:0] e;
    do_reset();
    pend_q.push_back(64'h40);
    exp_q.push_back(64'h80);
    step();  // cycle 0
    checks++;
    if (pops !== 1) begin errors++; $display("FAIL single_pop got %0d exp 1", pops); end
    step();  // cycle 1
    checks += 3;
    if (tags_q.size() !== 1 || tags_q[0] !== 2'd0) begin
      errors++; $display("FAIL single_tag got n=%0d exp one tag 0", tags_q.size());
    end
    if (addrs_q.size() !== 1 || addrs_q[0] !== 64'h40) begin
      errors++; $display("FAIL single_addr got n=%0d exp one addr 40", addrs_q.size());
    end
    if (bus.outstanding !== 3'd1) begin errors++; $display("FAIL single_outst got %0d exp 1", bus.outstanding); end
    for (int i = 2; i < 5; i++) step();
    set_rsp(1'b1, 2'd0, 64'h80);
    step();  // cycle 5
    set_rsp(1'b0, '0, '0);
    step();  // cycle 6
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL single_early_rsp got %0d exp 0", got_q.size()); end
    step();  // cycle 7
    checks += 2;
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL single_rsp_count got %0d exp 1", got_q.size());
    end else begin
      e = exp_q.pop_front();
      if (got_q[0] !== e) begin errors++; $display("FAIL single_rsp_data got %0h exp %0h", got_q[0], e); end
    end
    checks++;
    if (bus.outstanding !== 3'd0) begin errors++; $display("FAIL single_outst_end got %0d exp 0", bus.outstanding); end
  endtask

  task automatic test_reorder();
    logic [DEF_DATA_W-1:0] e;
    logic [DEF_TAG_W-1:0] t;
    do_reset();
    pend_q = '{64'h10, 64'h20, 64'h30};
    exp_q  = '{64'hA, 64'hB, 64'hC};
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (tags_q.size() !== 3) begin
      errors++; $display("FAIL reorder_issue_count got %0d exp 3", tags_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        t = DEF_TAG_W'(i);
        checks++;
        if (tags_q[i] !== t || addrs_q[i] !== 64'h10 * (i + 1)) begin
          errors++; $display("FAIL reorder_issue%0d got tag %0d addr %0h", i, tags_q[i], addrs_q[i]);
        end
      end
    end
    set_rsp(1'b1, 2'd2, 64'hC); step();
    set_rsp(1'b1, 2'd0, 64'hA); step();
    set_rsp(1'b1, 2'd1, 64'hB); step();
    set_rsp(1'b0, '0, '0);
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (got_q.size() !== 3) begin errors++; $display("FAIL reorder_rsp_count got %0d exp 3", got_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q[0] !== e) begin errors++; $display("FAIL reorder_rsp_data got %0h exp %0h", got_q[0], e); end
      void'(got_q.pop_front());
    end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL reorder_err got %0h exp 0", bus.err); end
  endtask

  task automatic test_full_stall();
    logic [DEF_DATA_W-1:0] e;
    do_reset();
    pend_q = '{64'h100, 64'h200, 64'h300, 64'h400, 64'h500};
    exp_q.push_back(64'hD0);
    for (int i = 0; i < 8; i++) step();
    checks += 3;
    if (pops !== 4) begin errors++; $display("FAIL full_pops got %0d exp 4", pops); end
    if (bus.outstanding !== 3'd4) begin errors++; $display("FAIL full_outst got %0d exp 4", bus.outstanding); end
    if (tags_q.size() !== 4 || tags_q[3] !== 2'd3) begin
      errors++; $display("FAIL full_tags got n=%0d exp 4 ending in tag 3", tags_q.size());
    end
    set_rsp(1'b1, 2'd0, 64'hD0);
    step();  // cycle N
    set_rsp(1'b0, '0, '0);
    step();  // N+1
    checks++;
    if (pops !== 4 || got_q.size() !== 0) begin
      errors++; $display("FAIL full_early_resume got pops=%0d rsp=%0d exp 4,0", pops, got_q.size());
    end
    step();  // N+2: retire visible, fifth pop
    checks += 2;
    if (pops !== 5) begin errors++; $display("FAIL full_resume_pop got %0d exp 5", pops); end
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL full_rsp_count got %0d exp 1", got_q.size());
    end else begin
      e = exp_q.pop_front();
      if (got_q[0] !== e) begin errors++; $display("FAIL full_rsp_data got %0h exp %0h", got_q[0], e); end
    end
    step();  // N+3
    checks++;
    if (tags_q.size() !== 5 || tags_q[4] !== 2'd0 || addrs_q[4] !== 64'h500) begin
      errors++; $display("FAIL full_wrap_issue got n=%0d exp 5th issue tag 0 addr 500", tags_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mem_rd_rdy = 1'b0;
    pend_q.push_back(64'h77);
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (pops !== 0 || tags_q.size() !== 0) begin
      errors++; $display("FAIL bp_stall got pops=%0d rd=%0d exp 0,0", pops, tags_q.size());
    end
    bus.mem_rd_rdy = 1'b1;
    step();
    checks++;
    if (pops !== 1) begin errors++; $display("FAIL bp_resume_pop got %0d exp 1", pops); end
    step();
    checks++;
    if (addrs_q.size() !== 1 || addrs_q[0] !== 64'h77) begin
      errors++; $display("FAIL bp_resume_rd got n=%0d exp one read of 77", addrs_q.size());
    end
  endtask

  task automatic test_errors();
    logic [DEF_DATA_W-1:0] e;
    do_reset();
    set_rsp(1'b1, 2'd3, 64'hDEAD);
    step();
    set_rsp(1'b0, '0, '0);
    step(); step();
    checks += 2;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL err_stray got %0h exp 1", bus.err); end
    if (got_q.size() !== 0) begin errors++; $display("FAIL err_stray_rsp got %0d exp 0", got_q.size()); end

    do_reset();
    pend_q.push_back(64'h55);
    exp_q.push_back(64'h1111);
    step(); step(); step();
    set_rsp(1'b1, 2'd0, 64'h1111);
    step();
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL err_good_rsp got %0h exp 0", bus.err); end
    set_rsp(1'b1, 2'd0, 64'h2222);
    step();
    set_rsp(1'b0, '0, '0);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL err_dup got %0h exp 1", bus.err); end
    step(); step(); step();
    checks++;
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL err_dup_rsp_count got %0d exp 1", got_q.size());
    end else begin
      e = exp_q.pop_front();
      if (got_q[0] !== e) begin errors++; $display("FAIL err_dup_data got %0h exp %0h", got_q[0], e); end
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    pend_q = '{64'hA00, 64'hB00, 64'hC00};
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (bus.outstanding !== 3'd3) begin errors++; $display("FAIL mid_outst got %0d exp 3", bus.outstanding); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req_pop !== 1'b0 || bus.rsp_val !== 1'b0 || bus.rsp_data !== '0 ||
        bus.mem_rd_val !== 1'b0 || bus.mem_rd_addr !== '0 || bus.mem_rd_tag !== '0 ||
        bus.outstanding !== '0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset got outst=%0d addr=%0h err=%0h exp all 0",
               bus.outstanding, bus.mem_rd_addr, bus.err);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    set_rsp(1'b1, 2'd1, 64'hBEEF);
    step();
    set_rsp(1'b0, '0, '0);
    step(); step(); step();
    checks += 3;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL mid_late_err got %0h exp 1", bus.err); end
    if (got_q.size() !== 0) begin errors++; $display("FAIL mid_late_rsp got %0d exp 0", got_q.size()); end
    if (bus.outstanding !== '0) begin errors++; $display("FAIL mid_late_outst got %0d exp 0", bus.outstanding); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_reorder();
    test_full_stall();
    test_backpressure();
    test_errors();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
